// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns byte/half/word requests into aligned word accesses on
// the mem interface, with read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [1:0] {IDLE, RD, CAPT, WR} state_t;

    state_t      state;
    logic        wen_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        legal;
    logic [ADDR_WIDTH-1:0] aligned;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign aligned   = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000:         legal = 1'b1;
            3'b001:         legal = ~req_addr[0];
            3'b010:         legal = (req_addr[1:0] == 2'b00);
            3'b100, 3'b101: legal = ~req_wen;
            default:        legal = 1'b0;
        endcase
    end

    // Little-endian lane select; funct3[2] marks the zero-extending variants.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'h0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'h0, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w, input logic [15:0] d);
        logic [31:0] m;
        m = w;
        if (f3[0]) begin
            if (off[1]) m[31:16] = d;
            else        m[15:0]  = d;
        end else begin
            m[{off, 3'b000} +: 8] = d[7:0];
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wen_q          <= 1'b0;
            f3_q           <= 3'b000;
            off_q          <= 2'b00;
            wdata_q        <= 16'h0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'h0;
            rsp_err        <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= 32'h0;
        end else begin
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_err      <= 1'b0;
            mem_write_en <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    wen_q   <= req_wen;
                    f3_q    <= req_funct3;
                    off_q   <= req_addr[1:0];
                    wdata_q <= req_wdata[15:0];
                    if (!legal) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (req_wen && req_funct3 == 3'b010) begin
                        // full-word store skips the read phase entirely
                        state          <= WR;
                        mem_write_en   <= 1'b1;
                        mem_addr       <= aligned;
                        mem_write_data <= req_wdata;
                    end else begin
                        state    <= RD;
                        mem_addr <= aligned;
                    end
                end
                RD: state <= CAPT;
                CAPT: begin
                    if (wen_q) begin
                        state          <= WR;
                        mem_write_en   <= 1'b1;
                        mem_write_data <= merge(f3_q, off_q, mem_read_data, wdata_q);
                    end else begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= extract(f3_q, off_q, mem_read_data);
                    end
                end
                WR: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small synchronous-read word memory model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    logic [31:0] mem [0:255];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[9:2]] <= mem_write_data;
        mem_read_data <= mem[mem_addr[9:2]];
    end

    // Issue one request and observe up to 8 cycles after the accept edge.
    task automatic run(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output int busy, output int wcnt,
                       output logic [31:0] rdata, output logic err,
                       output logic [31:0] waddr, output logic [31:0] wdat);
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; busy = 0; wcnt = 0; rdata = 32'h0; err = 1'b0; waddr = 32'h0; wdat = 32'h0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (!req_ready) busy++;
            if (mem_write_en) begin wcnt++; waddr = mem_addr; wdat = mem_write_data; end
            if (rsp_valid) begin lat = k; rdata = rsp_rdata; err = rsp_err; end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({rsp_valid, rsp_err, mem_write_en} !== 3'b000 || rsp_rdata !== 32'h0 ||
            mem_addr !== 32'h0 || mem_write_data !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got v=%b e=%b we=%b rd=%h a=%h wd=%h rdy=%b want all 0, rdy=1",
                     rsp_valid, rsp_err, mem_write_en, rsp_rdata, mem_addr, mem_write_data, req_ready);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        int lat, busy, wcnt; logic [31:0] rd, wa, wd; logic err;
        run(1'b0, 3'b010, 32'h100, 32'h0, lat, busy, wcnt, rd, err, wa, wd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'h8899AABB || err !== 1'b0) begin
            errors++; $display("FAIL lw_data got %h err=%b want 8899aabb err=0", rd, err); end
        checks++; if (busy !== 2) begin errors++; $display("FAIL lw_ready_low got %0d want 2", busy); end
        checks++; if (wcnt !== 0) begin errors++; $display("FAIL lw_no_write got %0d want 0", wcnt); end
    endtask

    task automatic test_subword_loads();
        logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] ad [5] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h103};
        logic [31:0] ex [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'hFFFFFF88};
        int lat, busy, wcnt; logic [31:0] rd, wa, wd; logic err;
        for (int i = 0; i < 5; i++) begin
            run(1'b0, f3[i], ad[i], 32'h0, lat, busy, wcnt, rd, err, wa, wd);
            checks++;
            if (lat !== 3 || rd !== ex[i] || err !== 1'b0 || wcnt !== 0) begin
                errors++;
                $display("FAIL subload_%0d got lat=%0d rd=%h err=%b w=%0d want lat=3 rd=%h err=0 w=0",
                         i, lat, rd, err, wcnt, ex[i]);
            end
        end
    endtask

    task automatic test_store_word();
        int lat, busy, wcnt; logic [31:0] rd, wa, wd; logic err;
        run(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, lat, busy, wcnt, rd, err, wa, wd);
        checks++; if (lat !== 2 || err !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL sw_rsp got lat=%0d err=%b rd=%h want 2 0 0", lat, err, rd); end
        checks++; if (wcnt !== 1 || wa !== 32'h104 || wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_write got n=%0d a=%h d=%h want 1 104 deadbeef", wcnt, wa, wd); end
        run(1'b0, 3'b010, 32'h104, 32'h0, lat, busy, wcnt, rd, err, wa, wd);
        checks++; if (rd !== 32'hDEADBEEF || lat !== 3) begin
            errors++; $display("FAIL sw_readback got %h lat=%0d want deadbeef 3", rd, lat); end
    endtask

    task automatic test_subword_stores();
        int lat, busy, wcnt; logic [31:0] rd, wa, wd; logic err;
        run(1'b1, 3'b000, 32'h102, 32'h12345677, lat, busy, wcnt, rd, err, wa, wd);
        checks++; if (lat !== 4 || err !== 1'b0) begin
            errors++; $display("FAIL sb_rsp got lat=%0d err=%b want 4 0", lat, err); end
        checks++; if (wcnt !== 1 || wa !== 32'h100 || wd !== 32'h8877AABB) begin
            errors++; $display("FAIL sb_write got n=%0d a=%h d=%h want 1 100 8877aabb", wcnt, wa, wd); end
        run(1'b1, 3'b001, 32'h100, 32'h0000CAFE, lat, busy, wcnt, rd, err, wa, wd);
        checks++; if (lat !== 4 || wcnt !== 1 || wd !== 32'h8877CAFE) begin
            errors++; $display("FAIL sh_write got lat=%0d n=%0d d=%h want 4 1 8877cafe", lat, wcnt, wd); end
        checks++; if (mem[8'h40] !== 32'h8877CAFE) begin
            errors++; $display("FAIL sh_mem got %h want 8877cafe", mem[8'h40]); end
    endtask

    task automatic test_back_to_back_errors();
        logic        wn [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3 [5] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100};
        logic [31:0] ad [5] = '{32'h101, 32'h102, 32'h106, 32'h100, 32'h100};
        int wcnt = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_wen = wn[i]; req_funct3 = f3[i]; req_addr = ad[i];
            req_wdata = 32'hFFFFFFFF;
            @(posedge clk);
            #1 if (i == 4) req_valid = 1'b0;
            @(negedge clk);
            if (mem_write_en) wcnt++;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL err_%0d got v=%b e=%b rd=%h rdy=%b want 1 1 0 1",
                         i, rsp_valid, rsp_err, rsp_rdata, req_ready);
            end
        end
        @(negedge clk);
        if (mem_write_en) wcnt++;
        checks++; if (wcnt !== 0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL err_quiet got writes=%0d v=%b want 0 0", wcnt, rsp_valid); end
    endtask

    task automatic test_reset_mid_write();
        int lat, busy, wcnt, seen_rsp; logic [31:0] rd, wa, wd; logic err;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b001; req_addr = 32'h100; req_wdata = 32'h1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_write_en) lat = k;
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rst_wr_reached got %0d want 3", lat); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, mem_write_en} !== 3'b000 || rsp_rdata !== 32'h0 ||
            mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs got v=%b e=%b we=%b rd=%h a=%h wd=%h want all 0",
                     rsp_valid, rsp_err, mem_write_en, rsp_rdata, mem_addr, mem_write_data);
        end
        seen_rsp = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid) seen_rsp++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (rsp_valid) seen_rsp++; end
        checks++; if (mem[8'h40] !== 32'h8877CAFE || seen_rsp !== 0) begin
            errors++; $display("FAIL rst_mem_kept got %h rsp=%0d want 8877cafe 0", mem[8'h40], seen_rsp); end
        run(1'b0, 3'b010, 32'h100, 32'h0, lat, busy, wcnt, rd, err, wa, wd);
        checks++; if (lat !== 3 || rd !== 32'h8877CAFE || err !== 1'b0) begin
            errors++; $display("FAIL rst_then_lw got lat=%0d rd=%h err=%b want 3 8877cafe 0", lat, rd, err); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h8899AABB;
        test_reset();
        test_load_word();
        test_subword_loads();
        test_store_word();
        test_subword_stores();
        test_back_to_back_errors();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit sitting between the core datapath and the word-addressed `mem` block, acting as the initiator on the `mem` interface. It accepts one load/store request at a time with an RV32I funct3 size code. It converts the request into word-aligned `mem` accesses: byte/half extraction with sign/zero extension for loads, read-modify-write for sub-word stores. It returns a single-cycle response pulse with data or an error flag.

Parameters:
ADDR_WIDTH, 32, width of request and memory addresses (data path fixed at 32 bits)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_wen  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data (low bits used for b/h)
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load result; 0 for stores and errors
rsp_err  output  1  misaligned or illegal funct3
mem_write_en  output  1  to mem.write_en
mem_addr  output  ADDR_WIDTH  to mem.addr, always word aligned ([1:0]=00)
mem_write_data  output  32  to mem.write_data
mem_read_data  input  32  from mem.read_data, valid the cycle after address is presented with write_en=0

Behaviour:
- Reset (async, immediate): state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_write_en=0, mem_addr=0, mem_write_data=0; captured request registers cleared.
- States: IDLE, RD, CAPT, WR.
- Accept: a handshake (req_valid & req_ready) at a rising edge captures req_* into internal registers.
- Legality check at accept:
  - Load funct3 must be in {000,001,010,100,101}; store funct3 must be in {000,001,010}.
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Illegal or misaligned: rsp_valid=1, rsp_err=1, rsp_rdata=0 in the next cycle; FSM stays IDLE; no mem access.
- Legal load: IDLE→RD→CAPT→IDLE.
  - RD and CAPT drive mem_addr={addr[31:2],00} with mem_write_en=0.
  - At the CAPT→IDLE edge, register the extracted lane into rsp_rdata and pulse rsp_valid.
  - rsp_valid is high in the 3rd cycle after the accept edge.
- Load extraction is little-endian:
  - b/bu take byte addr[1:0]; h/hu take half addr[1].
  - b/h sign-extend; bu/hu zero-extend; w passes through.
- Store word: IDLE→WR.
  - WR drives mem_write_en=1, aligned address, mem_write_data=req_wdata for exactly one cycle.
  - rsp_valid (err=0, rdata=0) is high in the 2nd cycle after accept.
- Store byte/half: IDLE→RD→CAPT→WR.
  - At the CAPT edge, merge req_wdata[7:0] or [15:0] into the selected lane of mem_read_data.
  - WR writes the merged word.
  - rsp_valid is high in the 4th cycle after accept.
- In IDLE: mem_write_en=0, mem_addr holds its last value, no writes.
- req_ready=1 only in IDLE. The rsp_valid cycle coincides with IDLE, so a new request may be accepted in the same cycle the response pulses.
- No response backpressure.
- Exactly one mem_write_en pulse per legal store; zero per load or error.
- Reset mid-operation: the transaction is abandoned, no response is issued, and an in-flight WR write is suppressed (write_en drops asynchronously).
- req_* changes while not accepted are ignored.

Test Plan:
- mem[0x100]=0x8899AABB; lw 0x100 → rsp_valid 3 cycles after accept, rsp_rdata=0x8899AABB, rsp_err=0, req_ready low for 2 cycles, no write_en.
- Same word: lb 0x101→0xFFFFFFAA; lbu 0x101→0x000000AA; lh 0x102→0xFFFF8899; lhu 0x102→0x00008899; lb 0x103→0xFFFFFF88.
- sw 0x104 data 0xDEADBEEF → single write_en pulse, addr 0x104, data 0xDEADBEEF; rsp 2 cycles after accept; subsequent lw 0x104 returns 0xDEADBEEF.
- sb 0x102 data 0x12345677 on 0x8899AABB → one read then one write of 0x8877AABB, rsp 4 cycles after accept; sh 0x100 data 0x0000CAFE → 0x8877CAFE.
- Errors: lh 0x101, lw 0x102, sw 0x106, load funct3=011, store funct3=100 → rsp_err=1, rsp_rdata=0 one cycle after accept; write_en never asserted; back-to-back requests accepted on consecutive cycles.
- Assert rst_n low during WR of sh 0x100 → mem_write_en drops immediately, memory unchanged, no rsp_valid, all outputs 0. After release, lw 0x100 completes normally.
